// File: rtl/multicycle_ctrl_pkg.sv
// Shared control encodings for the RV64 lab core: FSM states, instruction
// classes, opcodes and the ALUOp/TYPE codes consumed by ALU control.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_BRANCH = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_LD   = 3'd3,
        CLS_SD   = 3'd4,
        CLS_BR   = 3'd5
    } class_t;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] TYPE_R  = 3'd0;
    localparam logic [2:0] TYPE_I  = 3'd1;
    localparam logic [2:0] TYPE_LD = 3'd2;
    localparam logic [2:0] TYPE_SD = 3'd3;
    localparam logic [2:0] TYPE_BR = 3'd4;

    // Map an opcode to its instruction class; anything unsupported is CLS_NONE.
    function automatic class_t classify(input logic [6:0] opc);
        class_t cls;
        case (opc)
            OPC_R:   cls = CLS_R;
            OPC_I:   cls = CLS_I;
            OPC_LD:  cls = CLS_LD;
            OPC_SD:  cls = CLS_SD;
            OPC_BR:  cls = CLS_BR;
            default: cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// Memory-wait watchdog: counts consecutive requesting cycles without an ack
// and flags the cycle in which the wait reaches MEM_TIMEOUT.
module mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active,
    input  logic ack,
    output logic timeout
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt_r;
    logic          expire_s;

    // An ack in the final wait cycle wins over the timeout.
    always_comb begin
        expire_s = 1'b0;
        if (active && !ack && (wait_cnt_r == LAST_WAIT)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    assign timeout = expire_s;

    // Wait counter restarts whenever the request ends, is acked or expires.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_r <= '0;
        end else if (!active || ack || expire_s) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/BRANCH over one
// shared req/ack memory port, with retire counter and memory watchdog.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             halt_i,
    input  logic [6:0]       opcode_i,
    input  logic             funct3_0_i,
    input  logic             zero_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             addr_sel_o,
    output logic             ir_write_o,
    output logic             pc_inc_o,
    output logic             pc_load_o,
    output logic             reg_write_o,
    output logic             wb_sel_o,
    output logic             alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [2:0]       type_o,
    output logic [CNT_W-1:0] retired_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic             busy_o
);

    state_t           state_r;
    class_t           class_r;
    logic [CNT_W-1:0] retired_r;
    logic             err_gap_r;

    class_t     dec_class_s;
    state_t     boundary_s;
    logic       req_s;
    logic       timeout_s;
    logic       retire_s;
    logic       taken_s;
    logic [1:0] cls_alu_op_s;
    logic [2:0] cls_type_s;
    logic       cls_src_b_s;

    assign dec_class_s = classify(opcode_i);
    assign taken_s     = funct3_0_i ? ~zero_i : zero_i;
    assign boundary_s  = halt_i ? ST_IDLE : ST_FETCH;

    // The first FETCH cycle after a bus error keeps the port idle so the
    // aborted request is visibly dropped before a fresh one is issued.
    assign req_s = ((state_r == ST_FETCH) && !err_gap_r) || (state_r == ST_MEM);

    assign retire_s = (state_r == ST_WB) || (state_r == ST_BRANCH) ||
                      ((state_r == ST_MEM) && mem_ack_i && (class_r == CLS_SD));

    assign retired_o = retired_r;
    assign bus_err_o = timeout_s;

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .active  (req_s),
        .ack     (mem_ack_i),
        .timeout (timeout_s)
    );

    // ALU control fields implied by the registered instruction class.
    always_comb begin
        cls_alu_op_s = ALUOP_ADD;
        cls_type_s   = TYPE_R;
        cls_src_b_s  = 1'b0;
        case (class_r)
            CLS_R: begin
                cls_alu_op_s = ALUOP_FUNCT;
                cls_type_s   = TYPE_R;
                cls_src_b_s  = 1'b0;
            end
            CLS_I: begin
                cls_alu_op_s = ALUOP_FUNCT;
                cls_type_s   = TYPE_I;
                cls_src_b_s  = 1'b1;
            end
            CLS_LD: begin
                cls_alu_op_s = ALUOP_ADD;
                cls_type_s   = TYPE_LD;
                cls_src_b_s  = 1'b1;
            end
            CLS_SD: begin
                cls_alu_op_s = ALUOP_ADD;
                cls_type_s   = TYPE_SD;
                cls_src_b_s  = 1'b1;
            end
            default: begin
                cls_alu_op_s = ALUOP_ADD;
                cls_type_s   = TYPE_R;
                cls_src_b_s  = 1'b0;
            end
        endcase
    end

    // Control outputs decoded from state, class and the live inputs.
    always_comb begin
        mem_req_o   = req_s;
        mem_we_o    = 1'b0;
        addr_sel_o  = 1'b0;
        ir_write_o  = 1'b0;
        pc_inc_o    = 1'b0;
        pc_load_o   = 1'b0;
        reg_write_o = 1'b0;
        wb_sel_o    = 1'b0;
        alu_src_b_o = 1'b0;
        alu_op_o    = 2'b00;
        type_o      = 3'd0;
        illegal_o   = 1'b0;
        busy_o      = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                busy_o = 1'b0;
            end
            ST_FETCH: begin
                if (req_s) begin
                    ir_write_o = mem_ack_i;
                    pc_inc_o   = mem_ack_i;
                end else begin
                    ir_write_o = 1'b0;
                    pc_inc_o   = 1'b0;
                end
            end
            ST_DECODE: begin
                illegal_o = (dec_class_s == CLS_NONE);
            end
            ST_EXEC: begin
                alu_op_o    = cls_alu_op_s;
                type_o      = cls_type_s;
                alu_src_b_o = cls_src_b_s;
            end
            ST_MEM: begin
                addr_sel_o  = 1'b1;
                mem_we_o    = (class_r == CLS_SD);
                alu_op_o    = ALUOP_ADD;
                alu_src_b_o = 1'b1;
            end
            ST_WB: begin
                reg_write_o = 1'b1;
                wb_sel_o    = (class_r == CLS_LD);
                alu_op_o    = cls_alu_op_s;
                type_o      = cls_type_s;
                alu_src_b_o = cls_src_b_s;
            end
            ST_BRANCH: begin
                alu_op_o    = ALUOP_BR;
                type_o      = TYPE_BR;
                alu_src_b_o = 1'b0;
                pc_load_o   = taken_s;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // State sequencing, instruction class capture and retire counting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= ST_IDLE;
            class_r   <= CLS_NONE;
            retired_r <= '0;
            err_gap_r <= 1'b0;
        end else begin
            err_gap_r <= timeout_s;
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (!halt_i) begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (timeout_s) begin
                        state_r <= boundary_s;
                    end else if (req_s && mem_ack_i) begin
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    class_r <= dec_class_s;
                    case (dec_class_s)
                        CLS_R, CLS_I, CLS_LD, CLS_SD: state_r <= ST_EXEC;
                        CLS_BR:                       state_r <= ST_BRANCH;
                        default:                      state_r <= boundary_s;
                    endcase
                end
                ST_EXEC: begin
                    if ((class_r == CLS_LD) || (class_r == CLS_SD)) begin
                        state_r <= ST_MEM;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (timeout_s) begin
                        state_r <= boundary_s;
                    end else if (mem_ack_i) begin
                        state_r <= (class_r == CLS_SD) ? boundary_s : ST_WB;
                    end
                end
                ST_WB:     state_r <= boundary_s;
                ST_BRANCH: state_r <= boundary_s;
                default:   state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table plus
// hand-written watchdog, async-reset and halt sequences.
module tb_multicycle_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        halt_i;
    logic [6:0]  opcode_i;
    logic        funct3_0_i;
    logic        zero_i;
    logic        mem_ack_i;
    logic        mem_req_o, mem_we_o, addr_sel_o, ir_write_o, pc_inc_o;
    logic        pc_load_o, reg_write_o, wb_sel_o, alu_src_b_o;
    logic [1:0]  alu_op_o;
    logic [2:0]  type_o;
    logic [31:0] retired_o;
    logic        illegal_o, bus_err_o, busy_o;

    multicycle_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .halt_i      (halt_i),
        .opcode_i    (opcode_i),
        .funct3_0_i  (funct3_0_i),
        .zero_i      (zero_i),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .addr_sel_o  (addr_sel_o),
        .ir_write_o  (ir_write_o),
        .pc_inc_o    (pc_inc_o),
        .pc_load_o   (pc_load_o),
        .reg_write_o (reg_write_o),
        .wb_sel_o    (wb_sel_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_op_o    (alu_op_o),
        .type_o      (type_o),
        .retired_o   (retired_o),
        .illegal_o   (illegal_o),
        .bus_err_o   (bus_err_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    localparam int OP_R   = 'h33;
    localparam int OP_I   = 'h13;
    localparam int OP_LD  = 'h03;
    localparam int OP_SD  = 'h23;
    localparam int OP_BR  = 'h63;
    localparam int OP_BAD = 'h7F;

    typedef struct {
        int          halt;
        int          opc;
        int          f3;
        int          zero;
        int          ack;
        logic [16:0] exp;
        int          ret;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] act;
    assign act = {busy_o, mem_req_o, mem_we_o, addr_sel_o, ir_write_o, pc_inc_o,
                  pc_load_o, reg_write_o, wb_sel_o, alu_src_b_o, alu_op_o, type_o,
                  illegal_o, bus_err_o};

    function automatic logic [16:0] o(input int busy, input int req, input int we,
                                      input int asel, input int irw, input int pci,
                                      input int pcl, input int rw, input int wbs,
                                      input int srcb, input int aop, input int typ,
                                      input int ill, input int berr);
        return {busy[0], req[0], we[0], asel[0], irw[0], pci[0], pcl[0], rw[0],
                wbs[0], srcb[0], aop[1:0], typ[2:0], ill[0], berr[0]};
    endfunction

    function automatic vec_t mkv(input int halt, input int opc, input int f3,
                                 input int zero, input int ack,
                                 input logic [16:0] exp, input int ret);
        vec_t v;
        v.halt = halt; v.opc = opc; v.f3 = f3; v.zero = zero; v.ack = ack;
        v.exp = exp; v.ret = ret;
        return v;
    endfunction

    task automatic cyc(input int halt, input int opc, input int f3, input int zero,
                       input int ack);
        @(negedge clk_i);
        halt_i     = halt[0];
        opcode_i   = opc[6:0];
        funct3_0_i = f3[0];
        zero_i     = zero[0];
        mem_ack_i  = ack[0];
        #1;
    endtask

    task automatic chk(input string name, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: outputs got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ret(input string name, input int exp);
        logic [31:0] e;
        e = exp;
        n_checks++;
        if (retired_o !== e) begin
            n_errors++;
            $display("FAIL %s: retired_o got %0d expected %0d", name, retired_o, e);
        end
    endtask

    logic [16:0] e_idle, e_fetch_ack, e_fetch_wait, e_gap, e_berr, e_dec, e_dec_ill;
    logic [16:0] e_exec_r, e_wb_r, e_exec_i, e_wb_i, e_exec_ld, e_mem_ld, e_wb_ld;
    logic [16:0] e_exec_sd, e_mem_sd, e_br_t, e_br_n;
    vec_t tbl[32];

    initial begin
        //                  bsy req we as irw pci pcl rw wbs sb aop typ il be
        e_idle       = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_fetch_ack  = o(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        e_fetch_wait = o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_berr       = o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e_gap        = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_dec        = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_dec_ill    = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        e_exec_r     = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        e_wb_r       = o(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
        e_exec_i     = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        e_wb_i       = o(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 1, 0, 0);
        e_exec_ld    = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
        e_mem_ld     = o(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e_wb_ld      = o(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2, 0, 0);
        e_exec_sd    = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0);
        e_mem_sd     = o(1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e_br_t       = o(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4, 0, 0);
        e_br_n       = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);

        // R, I, LD (3-cycle ack delay), SD, BNE taken, BEQ not taken, illegal, BEQ taken
        tbl[0]  = mkv(0, OP_R,   0, 0, 0, e_idle,      0);
        tbl[1]  = mkv(0, OP_R,   0, 0, 1, e_fetch_ack, 0);
        tbl[2]  = mkv(0, OP_R,   0, 0, 0, e_dec,       0);
        tbl[3]  = mkv(0, OP_R,   0, 0, 0, e_exec_r,    0);
        tbl[4]  = mkv(0, OP_R,   0, 0, 1, e_wb_r,      0);
        tbl[5]  = mkv(0, OP_I,   0, 0, 1, e_fetch_ack, 1);
        tbl[6]  = mkv(0, OP_I,   0, 0, 0, e_dec,       1);
        tbl[7]  = mkv(0, OP_I,   0, 0, 0, e_exec_i,    1);
        tbl[8]  = mkv(0, OP_I,   0, 0, 0, e_wb_i,      1);
        tbl[9]  = mkv(0, OP_LD,  0, 0, 1, e_fetch_ack, 2);
        tbl[10] = mkv(0, OP_LD,  0, 0, 0, e_dec,       2);
        tbl[11] = mkv(0, OP_LD,  0, 0, 0, e_exec_ld,   2);
        tbl[12] = mkv(0, OP_LD,  0, 0, 0, e_mem_ld,    2);
        tbl[13] = mkv(0, OP_LD,  0, 0, 0, e_mem_ld,    2);
        tbl[14] = mkv(0, OP_LD,  0, 0, 0, e_mem_ld,    2);
        tbl[15] = mkv(0, OP_LD,  0, 0, 1, e_mem_ld,    2);
        tbl[16] = mkv(0, OP_LD,  0, 0, 0, e_wb_ld,     2);
        tbl[17] = mkv(0, OP_SD,  0, 0, 1, e_fetch_ack, 3);
        tbl[18] = mkv(0, OP_SD,  0, 0, 0, e_dec,       3);
        tbl[19] = mkv(0, OP_SD,  0, 0, 0, e_exec_sd,   3);
        tbl[20] = mkv(0, OP_SD,  0, 0, 1, e_mem_sd,    3);
        tbl[21] = mkv(0, OP_BR,  1, 0, 1, e_fetch_ack, 4);
        tbl[22] = mkv(0, OP_BR,  1, 0, 0, e_dec,       4);
        tbl[23] = mkv(0, OP_BR,  1, 0, 0, e_br_t,      4);
        tbl[24] = mkv(0, OP_BR,  0, 0, 1, e_fetch_ack, 5);
        tbl[25] = mkv(0, OP_BR,  0, 0, 0, e_dec,       5);
        tbl[26] = mkv(0, OP_BR,  0, 0, 0, e_br_n,      5);
        tbl[27] = mkv(0, OP_BAD, 0, 0, 1, e_fetch_ack, 6);
        tbl[28] = mkv(0, OP_BAD, 0, 0, 1, e_dec_ill,   6);
        tbl[29] = mkv(0, OP_BR,  0, 1, 1, e_fetch_ack, 6);
        tbl[30] = mkv(0, OP_BR,  0, 1, 1, e_dec,       6);
        tbl[31] = mkv(0, OP_BR,  0, 1, 0, e_br_t,      6);

        rst_i = 1'b0; halt_i = 1'b1; opcode_i = 7'd0;
        funct3_0_i = 1'b0; zero_i = 1'b0; mem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_outputs", e_idle);
        chk_ret("reset_retired", 0);
        rst_i = 1'b1;

        for (int i = 0; i < 32; i++) begin
            cyc(tbl[i].halt, tbl[i].opc, tbl[i].f3, tbl[i].zero, tbl[i].ack);
            chk($sformatf("vec%0d", i), tbl[i].exp);
            chk_ret($sformatf("vec%0d_ret", i), tbl[i].ret);
        end

        // FETCH with no ack: timeout on the 16th waiting cycle
        for (int i = 1; i <= 16; i++) begin
            cyc(0, OP_SD, 0, 0, 0);
            chk($sformatf("wd_wait%0d", i), (i == 16) ? e_berr : e_fetch_wait);
        end
        chk_ret("wd_no_retire", 7);
        cyc(0, OP_SD, 0, 0, 1);
        chk("wd_req_dropped", e_gap);
        // ack exactly on the 16th cycle is accepted, no bus error
        for (int i = 1; i <= 15; i++) begin
            cyc(0, OP_SD, 0, 0, 0);
            chk($sformatf("wd2_wait%0d", i), e_fetch_wait);
        end
        cyc(0, OP_SD, 0, 0, 1);
        chk("wd2_ack_on_last", e_fetch_ack);

        // store interrupted by asynchronous reset while in MEM
        cyc(0, OP_SD, 0, 0, 0);
        chk("sd_decode", e_dec);
        cyc(0, OP_SD, 0, 0, 0);
        chk("sd_exec", e_exec_sd);
        cyc(0, OP_SD, 0, 0, 0);
        chk("sd_mem_wait", e_mem_sd);
        chk_ret("sd_before_rst", 7);
        #1 rst_i = 1'b0;
        #1;
        chk("rst_async_outputs", e_idle);
        chk_ret("rst_async_retired", 0);
        @(negedge clk_i);
        #1;
        chk("rst_held", e_idle);
        halt_i = 1'b1;
        rst_i  = 1'b1;

        // R-type with halt raised before WB: retires then parks in IDLE
        cyc(0, OP_R, 0, 0, 0);
        chk("halt_idle0", e_idle);
        cyc(0, OP_R, 0, 0, 1);
        chk("halt_fetch", e_fetch_ack);
        cyc(0, OP_R, 0, 0, 0);
        chk("halt_decode", e_dec);
        cyc(1, OP_R, 0, 0, 0);
        chk("halt_exec", e_exec_r);
        cyc(1, OP_R, 0, 0, 0);
        chk("halt_wb", e_wb_r);
        cyc(1, OP_R, 0, 0, 0);
        chk("halt_idle1", e_idle);
        chk_ret("halt_retired", 1);
        cyc(1, OP_R, 0, 0, 1);
        chk("halt_idle2", e_idle);
        cyc(0, OP_R, 0, 0, 0);
        chk("halt_idle3", e_idle);
        cyc(0, OP_R, 0, 0, 0);
        chk("halt_refetch", e_fetch_wait);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not complete within 100000 time units");
        $fatal(1, "simulation time limit");
    end

endmodule
